// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency word-array responder for the RV32I memory bus
// Optional out-of-range checking of upper address bits: MEM_RESPONDER_RANGE_CHECK_EN
module mem_responder #(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        mem_err
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam int         DEPTH  = 1 << ADDR_BITS;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]  idx_q;
  logic [31:0]           wdata_q;
  logic [3:0]            be_q;
  logic                  wr_q;
  logic                  oor_q;
  logic [31:0]           rdata_q;
  logic                  err_q;
  logic [31:0]           mem_q [0:DEPTH-1];

  logic                  req;
  logic                  accept;
  logic                  oor_in;
  logic                  commit;
  logic                  in_idle;
  logic [ADDR_BITS-1:0]  idx_c;
  logic [31:0]           wdata_c;
  logic [3:0]            be_c;
  logic                  wr_c;
  logic                  oor_c;

  assign req     = mem_read | mem_write;
  assign in_idle = (state_q == IDLE);
  assign accept  = in_idle && req;

`ifdef MEM_RESPONDER_RANGE_CHECK_EN
  logic unused_addr;
  assign oor_in      = |mem_address[31:ADDR_BITS+2];
  assign unused_addr = ^mem_address[1:0];
`else
  logic unused_addr;
  assign oor_in      = 1'b0;
  assign unused_addr = ^{mem_address[31:ADDR_BITS+2], mem_address[1:0]};
`endif

  // With LATENCY==1 the commit edge is the acceptance edge, so the live inputs are used.
  assign idx_c   = in_idle ? mem_address[ADDR_BITS+1:2] : idx_q;
  assign wdata_c = in_idle ? mem_wdata                  : wdata_q;
  assign be_c    = in_idle ? mem_byte_enable            : be_q;
  assign wr_c    = in_idle ? mem_write                  : wr_q;
  assign oor_c   = in_idle ? oor_in                     : oor_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (LATENCY == 1) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = LAT_M1;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      wr_q    <= 1'b0;
      oor_q   <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q   <= mem_address[ADDR_BITS+1:2];
        wdata_q <= mem_wdata;
        be_q    <= mem_byte_enable;
        wr_q    <= mem_write;
        oor_q   <= oor_in;
        if ((mem_read && mem_write) || oor_in) err_q <= 1'b1;
      end
      if (commit && !wr_c) rdata_q <= oor_c ? 32'h0 : mem_q[idx_c];
    end
  end

  // Array contents survive reset; a reset edge suppresses any pending commit.
  always_ff @(posedge clk) begin
    if (rst && commit && wr_c && !oor_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be_c[i]) mem_q[idx_c][8*i +: 8] <= wdata_c[8*i +: 8];
      end
    end
  end

  assign mem_resp  = (state_q == RESP);
  assign mem_rdata = rdata_q;
  assign mem_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized self-checking bench for mem_responder
// Checks a LATENCY=3 instance against a word-array model, plus a LATENCY=1 instance.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_address, mem_wdata;
  logic [31:0] mem_rdata, rdata1;
  logic        mem_resp, resp1, mem_err, err1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] ref_mem [0:255];
  logic [31:0] ref_rdata;
  logic        ref_err;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_BITS(8), .LATENCY(3)) u_dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .mem_err(mem_err)
  );

  mem_responder #(.ADDR_BITS(8), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(rdata1), .mem_resp(resp1), .mem_err(err1)
  );

  function automatic logic model_oor(input logic [31:0] a);
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    return a[31:10] != 22'h0;
`else
    return 1'b0;
`endif
  endfunction

  // Reference behaviour of one completed access on the 256-word memory.
  task automatic model_access(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] wd, input logic [3:0] be);
    int idx;
    logic [31:0] w;
    idx = (a / 4) % 256;
    if ((rd && wr) || model_oor(a)) ref_err = 1'b1;
    if (wr) begin
      if (!model_oor(a)) begin
        w = ref_mem[idx];
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
        ref_mem[idx] = w;
      end
    end else begin
      ref_rdata = model_oor(a) ? 32'h0 : ref_mem[idx];
    end
  endtask

  // Drives one request from an IDLE cycle, holds it until mem_resp, returns latency and rdata.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be,
                        output int lat, output logic [31:0] rdv);
    mem_read = rd; mem_write = wr; mem_address = a; mem_wdata = wd; mem_byte_enable = be;
    lat = -1;
    rdv = 32'h0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (mem_resp) begin
        lat = c;
        rdv = mem_rdata;
        break;
      end
    end
    mem_read = 1'b0; mem_write = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; mem_read = 0; mem_write = 0; mem_byte_enable = 0; mem_address = 0; mem_wdata = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    ref_rdata = 32'h0; ref_err = 1'b0;
    n_cmp++; if (mem_resp !== 1'b0) begin n_bad++; $display("FAIL reset_resp got %b want 0", mem_resp); end
    n_cmp++; if (mem_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got %h want 0", mem_rdata); end
    n_cmp++; if (mem_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", mem_err); end
  endtask

  task automatic test_fill;
    int lat; logic [31:0] rdv, d;
    int bad = 0;
    for (int i = 0; i < 256; i++) begin
      d = $urandom;
      access(1'b0, 1'b1, 32'(i * 4), d, 4'hF, lat, rdv);
      model_access(1'b0, 1'b1, 32'(i * 4), d, 4'hF);
      if (lat != 3) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL fill_latency got %0d bad want 0", bad); end
  endtask

  task automatic test_write_read;
    int lat; logic [31:0] rdv;
    access(1'b0, 1'b1, 32'h10, 32'hCAFEBABE, 4'hF, lat, rdv);
    model_access(1'b0, 1'b1, 32'h10, 32'hCAFEBABE, 4'hF);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL wr_latency got %0d want 3", lat); end
    n_cmp++; if (rdv !== ref_rdata) begin n_bad++; $display("FAIL wr_rdata_held got %h want %h", rdv, ref_rdata); end
    access(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, lat, rdv);
    model_access(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL rd_latency got %0d want 3", lat); end
    n_cmp++; if (rdv !== 32'hCAFEBABE) begin n_bad++; $display("FAIL rd_data got %h want cafebabe", rdv); end
  endtask

  task automatic test_byte_merge;
    int lat; logic [31:0] rdv;
    access(1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, lat, rdv);
    model_access(1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF);
    access(1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, lat, rdv);
    model_access(1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
    access(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, lat, rdv);
    model_access(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    n_cmp++; if (rdv !== 32'h11BB33DD) begin n_bad++; $display("FAIL merge_0101 got %h want 11bb33dd", rdv); end
    access(1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, lat, rdv);
    model_access(1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL be0_latency got %0d want 3", lat); end
    access(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, lat, rdv);
    model_access(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    n_cmp++; if (rdv !== 32'h11BB33DD) begin n_bad++; $display("FAIL merge_be0 got %h want 11bb33dd", rdv); end
  endtask

  task automatic test_back_to_back;
    logic [11:0] seen = '0;
    mem_read = 1'b1; mem_write = 1'b0; mem_address = 32'h10;
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk); #1;
      if (mem_resp) seen[c] = 1'b1;
    end
    mem_read = 1'b0;
    @(posedge clk); #1;
    model_access(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    n_cmp++; if (seen !== 12'b1000_1000_1000) begin n_bad++; $display("FAIL b2b_pulses got %b want 100010001000", seen); end
    n_cmp++; if (mem_rdata !== ref_rdata) begin n_bad++; $display("FAIL b2b_rdata got %h want %h", mem_rdata, ref_rdata); end
  endtask

  task automatic test_latency1;
    logic [31:0] a;
    a = 32'h0C0;
    mem_read = 1'b1; mem_write = 1'b0; mem_address = a;
    @(posedge clk); #1;
    n_cmp++; if (resp1 !== 1'b1) begin n_bad++; $display("FAIL lat1_resp_t1 got %b want 1", resp1); end
    n_cmp++; if (rdata1 !== ref_mem[48]) begin n_bad++; $display("FAIL lat1_rdata got %h want %h", rdata1, ref_mem[48]); end
    mem_read = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (resp1 !== 1'b0) begin n_bad++; $display("FAIL lat1_resp_t2 got %b want 0", resp1); end
    @(posedge clk); #1;
    n_cmp++; if (mem_resp !== 1'b1) begin n_bad++; $display("FAIL lat3_dropped_req got %b want 1", mem_resp); end
    @(posedge clk); #1;
    model_access(1'b1, 1'b0, a, 32'h0, 4'h0);
  endtask

  task automatic test_collision;
    int lat; logic [31:0] rdv, d, prev;
    d = $urandom;
    prev = ref_rdata;
    access(1'b1, 1'b1, 32'h44, d, 4'hF, lat, rdv);
    model_access(1'b1, 1'b1, 32'h44, d, 4'hF);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL coll_latency got %0d want 3", lat); end
    n_cmp++; if (rdv !== prev) begin n_bad++; $display("FAIL coll_rdata got %h want %h", rdv, prev); end
    n_cmp++; if (mem_err !== 1'b1) begin n_bad++; $display("FAIL coll_err got %b want 1", mem_err); end
    n_cmp++; if (err1 !== 1'b1) begin n_bad++; $display("FAIL coll_err_lat1 got %b want 1", err1); end
    access(1'b1, 1'b0, 32'h44, 32'h0, 4'h0, lat, rdv);
    model_access(1'b1, 1'b0, 32'h44, 32'h0, 4'h0);
    n_cmp++; if (rdv !== d) begin n_bad++; $display("FAIL coll_written got %h want %h", rdv, d); end
    n_cmp++; if (mem_err !== ref_err) begin n_bad++; $display("FAIL coll_err_sticky got %b want %b", mem_err, ref_err); end
  endtask

  task automatic test_reset_mid;
    int lat, pulses; logic [31:0] rdv, d;
    d = ~ref_mem[32];
    mem_read = 1'b0; mem_write = 1'b1; mem_address = 32'h80; mem_wdata = d; mem_byte_enable = 4'hF;
    @(posedge clk); #1;
    rst = 1'b0; mem_write = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    ref_err = 1'b0; ref_rdata = 32'h0;
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      if (mem_resp) pulses++;
      @(posedge clk); #1;
    end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL rstmid_resp got %0d pulses want 0", pulses); end
    n_cmp++; if (mem_err !== 1'b0) begin n_bad++; $display("FAIL rstmid_err got %b want 0", mem_err); end
    n_cmp++; if (mem_rdata !== 32'h0) begin n_bad++; $display("FAIL rstmid_rdata got %h want 0", mem_rdata); end
    access(1'b1, 1'b0, 32'h80, 32'h0, 4'h0, lat, rdv);
    model_access(1'b1, 1'b0, 32'h80, 32'h0, 4'h0);
    n_cmp++; if (rdv !== ref_rdata) begin n_bad++; $display("FAIL rstmid_word got %h want %h", rdv, ref_rdata); end
  endtask

  task automatic test_range;
    int lat; logic [31:0] rdv, d;
    d = $urandom;
    access(1'b0, 1'b1, 32'h400, d, 4'hF, lat, rdv);
    model_access(1'b0, 1'b1, 32'h400, d, 4'hF);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL range_latency got %0d want 3", lat); end
    n_cmp++; if (mem_err !== ref_err) begin n_bad++; $display("FAIL range_err got %b want %b", mem_err, ref_err); end
    access(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, lat, rdv);
    model_access(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    n_cmp++; if (rdv !== ref_rdata) begin n_bad++; $display("FAIL range_word0 got %h want %h", rdv, ref_rdata); end
    access(1'b1, 1'b0, 32'h400, 32'h0, 4'h0, lat, rdv);
    model_access(1'b1, 1'b0, 32'h400, 32'h0, 4'h0);
    n_cmp++; if (rdv !== ref_rdata) begin n_bad++; $display("FAIL range_read got %h want %h", rdv, ref_rdata); end
  endtask

  task automatic test_random;
    int lat; logic [31:0] rdv, a, d; logic rd; logic [3:0] be;
    for (int i = 0; i < 40; i++) begin
      rd = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 1023));
      d  = $urandom;
      be = 4'($urandom_range(0, 15));
      access(rd, !rd, a, d, be, lat, rdv);
      model_access(rd, !rd, a, d, be);
      n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL rand_latency[%0d] got %0d want 3", i, lat); end
      n_cmp++; if (rdv !== ref_rdata) begin n_bad++; $display("FAIL rand_rdata[%0d] got %h want %h", i, rdv, ref_rdata); end
    end
    n_cmp++; if (mem_err !== ref_err) begin n_bad++; $display("FAIL rand_err got %b want %b", mem_err, ref_err); end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_write_read;
    test_byte_merge;
    test_back_to_back;
    test_latency1;
    test_collision;
    test_reset_mid;
    test_range;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Synthesizable memory-side responder for the multicycle RV32I core's memory bus.
- Accepts `mem_read`/`mem_write` requests from the core's control/datapath and services them from an internal word array after a fixed, parameterised latency.
- Answers each request with a one-cycle `mem_resp` pulse.
- Used as the bench/FPGA memory behind the core.

Parameters:
- ADDR_BITS, 8, number of word-address bits; array depth is 2**ADDR_BITS 32-bit words.
- LATENCY, 3, cycles from request acceptance to the `mem_resp` pulse; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset.
- mem_read  input  1  read request; held by initiator until `mem_resp`.
- mem_write  input  1  write request; held by initiator until `mem_resp`.
- mem_byte_enable  input  4  write byte lanes; bit i enables `mem_wdata[8i+7:8i]`.
- mem_address  input  32  byte address; bits [1:0] ignored.
- mem_wdata  input  32  write data.
- mem_rdata  output  32  read data, registered.
- mem_resp  output  1  one-cycle completion pulse.
- mem_err  output  1  sticky protocol/range error flag.

Behaviour:
- Reset (`rst`==0 at an edge):
  - State goes to IDLE.
  - `mem_resp`=0, `mem_rdata`=32'h0, `mem_err`=0, latency counter=0.
  - Array contents are not reset.
  - Reset mid-transaction aborts it: no `mem_resp`, and no array write if not yet committed.
- Word index = `mem_address[ADDR_BITS+1:2]`.
- States IDLE, BUSY, RESP:
  - IDLE: at an edge with `mem_read`|`mem_write`, latch address, wdata, byte_enable and op into internal registers (acceptance).
    - LATENCY==1: go to RESP.
    - Otherwise: go to BUSY with counter=LATENCY-1.
  - BUSY: counter decrements each cycle; when counter==1, go to RESP at the next edge.
  - RESP: `mem_resp`=1 for exactly this one cycle; next state is IDLE unconditionally.
- Latency: request accepted in cycle T gives `mem_resp` high in cycle T+LATENCY.
- Request/response handshake:
  - The request is still high during the RESP cycle by protocol and is ignored there; it is not re-accepted.
  - A new request is first sampled in the IDLE cycle after RESP.
  - Minimum spacing between responses is LATENCY+1 cycles.
- Write commit:
  - The write commits to the array at the edge entering RESP, using only enabled lanes.
  - Disabled lanes keep their old bytes.
  - A read accepted after the write observes the new data.
- Read data:
  - `mem_rdata` loads the full array word at the edge entering RESP.
  - It holds that value until the next read completes; writes do not change `mem_rdata`.
- Both `mem_read` and `mem_write` high at acceptance:
  - Treated as a write only.
  - `mem_err` set.
- Request changes or drops while BUSY:
  - The transaction completes with the latched values.
  - `mem_resp` still pulses.
  - No error is flagged.
- `mem_err` clears only on reset.
- `byte_enable`==4'b0000 on a write: the access completes normally and the array is unchanged.

Optional Feature:
- Macro `MEM_RESPONDER_RANGE_CHECK_EN`.
- Defined:
  - Any accepted access with `mem_address[31:ADDR_BITS+2]` nonzero is out of range.
  - The write is dropped.
  - Read returns 32'h0.
  - `mem_err` is set.
  - `mem_resp` still pulses at normal latency.
- Undefined:
  - Upper address bits are ignored; addresses alias modulo 2**(ADDR_BITS+2) bytes.
  - `mem_err` is set only by read+write collisions.

Test Plan:
- Write, then read back (LATENCY=3, enables 4'hF):
  - Write 32'hCAFEBABE to 32'h0000_0010, enables 4'hF → `mem_resp` in cycle 3 after acceptance.
  - Read of 32'h10 then returns 32'hCAFEBABE with `mem_resp` 3 cycles after its acceptance.
- Byte-lane merge (LATENCY=3):
  - Word 32'h11223344 at 32'h20.
  - Write 32'hAABBCCDD with enables 4'b0101 → read returns 32'h11BB33DD.
- Back-to-back requests (LATENCY=3):
  - Initiator holds `mem_read` continuously across two transactions → responses exactly 4 cycles apart.
  - The RESP cycle does not trigger a duplicate acceptance.
- LATENCY=1 build:
  - Read accepted in cycle T → `mem_resp` high in T+1 only.
  - `mem_rdata` valid in T+1.
- Collision and reset:
  - `mem_read`=`mem_write`=1 → treated as write, `mem_err`=1 and stays set.
  - Assert `rst`=0 while BUSY → no `mem_resp`, `mem_err`=0, the target word is unchanged on a subsequent read.
- Range check:
  - With `MEM_RESPONDER_RANGE_CHECK_EN` and ADDR_BITS=8, write to 32'h0000_0400 → array unchanged, `mem_err`=1.
  - Without the macro, the same write lands at word 0 and a read of 32'h0 returns the data.
